// File: rtl/fetch_stage.sv
// fetch_stage: sequential-PC instruction fetch with 1-cycle sync imem and IF/ID register.
// A one-entry hold buffer catches a returning word while ID is stalled.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        id_valid
);
    logic [31:0] pc_f, req_pc, hold_inst, hold_pc;
    logic        req_valid, hold_valid;

    // No issue while the hold buffer is occupied, so req_valid and hold_valid never coexist
    assign imem_en   = rst_n & ~stall & ~redirect & ~hold_valid;
    assign imem_addr = pc_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f       <= RESET_PC;
            req_valid  <= 1'b0;
            req_pc     <= '0;
            hold_valid <= 1'b0;
            hold_inst  <= NOP_INST;
            hold_pc    <= '0;
            id_inst    <= NOP_INST;
            id_pc      <= '0;
            id_valid   <= 1'b0;
        end else if (redirect) begin
            pc_f       <= redirect_pc & ~32'd3;
            req_valid  <= 1'b0;
            hold_valid <= 1'b0;
            id_valid   <= 1'b0;
            id_inst    <= NOP_INST;
        end else begin
            req_valid <= imem_en;
            if (imem_en) begin
                req_pc <= pc_f;
                pc_f   <= pc_f + 32'd4;
            end
            if (!stall) begin
                if (req_valid) begin
                    id_inst  <= imem_rdata;
                    id_pc    <= req_pc;
                    id_valid <= 1'b1;
                end else if (hold_valid) begin
                    id_inst    <= hold_inst;
                    id_pc      <= hold_pc;
                    id_valid   <= 1'b1;
                    hold_valid <= 1'b0;
                end else begin
                    id_inst  <= NOP_INST;
                    id_valid <= 1'b0;
                end
            end else if (req_valid) begin
                hold_inst  <= imem_rdata;
                hold_pc    <= req_pc;
                hold_valid <= 1'b1;
            end
        end
    end
endmodule
